// File: rtl/mdu_hilo.sv
// Multi-cycle multiply/divide unit with architectural HI/LO registers.
// Shift-add multiply and restoring divide on magnitudes, sign fixup in FIX.
module mdu_hilo #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 6
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] rs_data,
    input  logic [WIDTH-1:0] rt_data,
    input  logic             hi_we,
    input  logic             lo_we,
    input  logic [WIDTH-1:0] wdata,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_FIX} state_t;

    state_t             state_q;
    logic               is_div_q;
    logic               neg_q;
    logic               rneg_q;
    logic               divz_q;
    logic [WIDTH-1:0]   b_q;
    logic [WIDTH-1:0]   rsraw_q;
    logic [2*WIDTH-1:0] acc_q;
    logic [CNT_W-1:0]   cnt_q;
    logic [WIDTH-1:0]   hi_q;
    logic [WIDTH-1:0]   lo_q;
    logic               busy_q;
    logic               done_q;

    logic               rs_neg;
    logic               rt_neg;
    logic [WIDTH-1:0]   rs_mag;
    logic [WIDTH-1:0]   rt_mag;
    logic [WIDTH:0]     mul_sum;
    logic [WIDTH:0]     div_sh;
    logic [WIDTH:0]     div_diff;
    logic [2*WIDTH-1:0] step_d;
    logic [2*WIDTH-1:0] prod_fix;
    logic [WIDTH-1:0]   quo_fix;
    logic [WIDTH-1:0]   rem_fix;

    always_comb begin
        rs_neg = op[0] & rs_data[WIDTH-1];
        rt_neg = op[0] & rt_data[WIDTH-1];
        rs_mag = rs_neg ? -rs_data : rs_data;
        rt_mag = rt_neg ? -rt_data : rt_data;
    end

    // acc holds {partial, multiplier} for MUL and {remainder, dividend} for DIV
    always_comb begin
        mul_sum  = {1'b0, acc_q[2*WIDTH-1:WIDTH]}
                 + {1'b0, (acc_q[0] ? b_q : {WIDTH{1'b0}})};
        div_sh   = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-1]};
        div_diff = div_sh - {1'b0, b_q};
        if (!is_div_q)
            step_d = {mul_sum, acc_q[WIDTH-1:1]};
        else if (div_diff[WIDTH])
            step_d = {div_sh[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b0};
        else
            step_d = {div_diff[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b1};
    end

    always_comb begin
        prod_fix = neg_q ? -acc_q : acc_q;
        quo_fix  = neg_q ? -acc_q[WIDTH-1:0] : acc_q[WIDTH-1:0];
        rem_fix  = rneg_q ? -acc_q[2*WIDTH-1:WIDTH]
                          : acc_q[2*WIDTH-1:WIDTH];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= S_IDLE;
            is_div_q <= 1'b0;
            neg_q    <= 1'b0;
            rneg_q   <= 1'b0;
            divz_q   <= 1'b0;
            b_q      <= '0;
            rsraw_q  <= '0;
            acc_q    <= '0;
            cnt_q    <= '0;
            hi_q     <= '0;
            lo_q     <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            done_q <= 1'b0;
            unique case (state_q)
                S_IDLE: begin
                    if (start) begin
                        is_div_q <= op[1];
                        neg_q    <= rs_neg ^ rt_neg;
                        rneg_q   <= rs_neg;
                        divz_q   <= op[1] & (rt_data == '0);
                        rsraw_q  <= rs_data;
                        b_q      <= op[1] ? rt_mag : rs_mag;
                        acc_q    <= {{WIDTH{1'b0}},
                                     (op[1] ? rs_mag : rt_mag)};
                        cnt_q    <= '0;
                        busy_q   <= 1'b1;
                        state_q  <= S_RUN;
                    end else begin
                        if (hi_we) hi_q <= wdata;
                        if (lo_we) lo_q <= wdata;
                    end
                end
                S_RUN: begin
                    acc_q <= step_d;
                    cnt_q <= cnt_q + 1'b1;
                    if (cnt_q == CNT_W'(WIDTH-1))
                        state_q <= S_FIX;
                end
                S_FIX: begin
                    if (!is_div_q) begin
                        hi_q <= prod_fix[2*WIDTH-1:WIDTH];
                        lo_q <= prod_fix[WIDTH-1:0];
                    end else if (divz_q) begin
                        hi_q <= rsraw_q;
                        lo_q <= {WIDTH{1'b1}};
                    end else begin
                        hi_q <= rem_fix;
                        lo_q <= quo_fix;
                    end
                    done_q  <= 1'b1;
                    busy_q  <= 1'b0;
                    state_q <= S_IDLE;
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign busy = busy_q;
    assign done = done_q;
    assign hi   = hi_q;
    assign lo   = lo_q;

endmodule

// File: tb/tb_mdu_hilo.sv
// Directed bench for mdu_hilo: table of MULT/DIV vectors plus
// hand-written sequences for MTHI/MTLO, start-while-busy and reset.
module tb_mdu_hilo;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [1:0]  op;
    logic [31:0] rs_data;
    logic [31:0] rt_data;
    logic        hi_we;
    logic        lo_we;
    logic [31:0] wdata;
    logic        busy;
    logic        done;
    logic [31:0] hi;
    logic [31:0] lo;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    mdu_hilo dut (
        .clk     (clk),
        .rst     (rst),
        .start   (start),
        .op      (op),
        .rs_data (rs_data),
        .rt_data (rt_data),
        .hi_we   (hi_we),
        .lo_we   (lo_we),
        .wdata   (wdata),
        .busy    (busy),
        .done    (done),
        .hi      (hi),
        .lo      (lo)
    );

    typedef struct {
        logic [1:0]  op;
        logic [31:0] rs;
        logic [31:0] rt;
        logic [31:0] hi;
        logic [31:0] lo;
    } vec_t;

    vec_t tv[12];

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // One operation; inj_k >= 0 pulses start+hi_we while busy,
    // lo_ws asserts lo_we together with start.
    task automatic run_op(input string nm, input logic [1:0] o,
                          input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] eh, input logic [31:0] el,
                          input int inj_k, input bit lo_ws);
        logic [31:0] ph, pl, gh, gl;
        int nb, nd;
        bit held;
        @(negedge clk);
        ph = hi;
        pl = lo;
        start = 1'b1;
        op = o;
        rs_data = a;
        rt_data = b;
        if (lo_ws) begin
            lo_we = 1'b1;
            wdata = 32'h1111_1111;
        end
        @(negedge clk);
        start = 1'b0;
        lo_we = 1'b0;
        hi_we = 1'b0;
        rs_data = ~a;
        rt_data = ~b;
        nb = 0;
        nd = 0;
        held = 1'b1;
        gh = 32'hDEAD_BEEF;
        gl = 32'hDEAD_BEEF;
        for (int k = 0; k < 40; k++) begin
            if (busy) begin
                nb++;
                if (hi !== ph || lo !== pl) held = 1'b0;
            end
            if (done) begin
                nd++;
                gh = hi;
                gl = lo;
            end
            if (k == inj_k) begin
                start = 1'b1;
                hi_we = 1'b1;
                wdata = 32'h0000_1234;
            end else if (k == inj_k + 1) begin
                start = 1'b0;
                hi_we = 1'b0;
            end
            @(negedge clk);
        end
        chk({nm, " busy_cycles"}, 32'(nb), 32'd33);
        chk({nm, " done_pulses"}, 32'(nd), 32'd1);
        chk({nm, " hold"}, {31'b0, held}, 32'd1);
        chk({nm, " hi"}, gh, eh);
        chk({nm, " lo"}, gl, el);
    endtask

    initial begin
        int nd;
        tv[0]  = '{2'b00, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001};
        tv[1]  = '{2'b01, 32'hFFFFFFFD, 32'h00000005, 32'hFFFFFFFF, 32'hFFFFFFF1};
        tv[2]  = '{2'b11, 32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFF, 32'hFFFFFFFD};
        tv[3]  = '{2'b10, 32'h00000064, 32'h00000000, 32'h00000064, 32'hFFFFFFFF};
        tv[4]  = '{2'b11, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000};
        tv[5]  = '{2'b00, 32'h00000006, 32'h00000007, 32'h00000000, 32'h0000002A};
        tv[6]  = '{2'b11, 32'h00000007, 32'hFFFFFFFE, 32'h00000001, 32'hFFFFFFFD};
        tv[7]  = '{2'b10, 32'hFFFFFFFF, 32'h00000010, 32'h0000000F, 32'h0FFFFFFF};
        tv[8]  = '{2'b01, 32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000};
        tv[9]  = '{2'b01, 32'h7FFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h80000001};
        tv[10] = '{2'b11, 32'hFFFFFFF9, 32'h00000000, 32'hFFFFFFF9, 32'hFFFFFFFF};
        tv[11] = '{2'b00, 32'h12345678, 32'h00000000, 32'h00000000, 32'h00000000};

        rst = 1'b1;
        start = 1'b0;
        op = 2'b00;
        rs_data = '0;
        rt_data = '0;
        hi_we = 1'b0;
        lo_we = 1'b0;
        wdata = '0;
        repeat (2) @(negedge clk);
        chk("reset busy", {31'b0, busy}, 32'd0);
        chk("reset done", {31'b0, done}, 32'd0);
        chk("reset hi", hi, 32'd0);
        chk("reset lo", lo, 32'd0);
        rst = 1'b0;

        for (int i = 0; i < 12; i++)
            run_op($sformatf("vec%0d", i), tv[i].op, tv[i].rs, tv[i].rt,
                   tv[i].hi, tv[i].lo, -1, 1'b0);

        run_op("divu_busy_start", 2'b10, 32'd10, 32'd3,
               32'd1, 32'd3, 5, 1'b0);

        // reset in the middle of a MULT
        @(negedge clk);
        start = 1'b1;
        op = 2'b01;
        rs_data = 32'd3;
        rt_data = 32'd5;
        @(negedge clk);
        start = 1'b0;
        repeat (11) @(negedge clk);
        rst = 1'b1;
        #1;
        chk("midrst busy", {31'b0, busy}, 32'd0);
        chk("midrst done", {31'b0, done}, 32'd0);
        chk("midrst hi", hi, 32'd0);
        chk("midrst lo", lo, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        nd = 0;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            if (done || busy) nd++;
        end
        chk("midrst no_done", 32'(nd), 32'd0);
        run_op("multu_after_rst", 2'b00, 32'd6, 32'd7,
               32'd0, 32'd42, -1, 1'b0);

        // MTHI/MTLO in IDLE
        @(negedge clk);
        hi_we = 1'b1;
        lo_we = 1'b1;
        wdata = 32'hA5A5_A5A5;
        @(negedge clk);
        hi_we = 1'b0;
        lo_we = 1'b0;
        chk("mt both hi", hi, 32'hA5A5_A5A5);
        chk("mt both lo", lo, 32'hA5A5_A5A5);
        hi_we = 1'b1;
        wdata = 32'h5A5A_5A5A;
        @(negedge clk);
        hi_we = 1'b0;
        chk("mthi hi", hi, 32'h5A5A_5A5A);
        chk("mthi lo", lo, 32'hA5A5_A5A5);

        run_op("start_with_lowe", 2'b00, 32'd6, 32'd7,
               32'd0, 32'd42, -1, 1'b1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/mdu_hilo.md
Name: mdu_hilo

Overview:
Multi-cycle multiply/divide unit with architectural HI/LO registers for the single-cycle MIPS core. It sits directly downstream of the general-purpose register file and consumes read_data1 (rs) and read_data2 (rt) for MULT/MULTU/DIV/DIVU. It asserts busy so the control path stalls the PC while an operation runs. It also services MTHI/MTLO writes and drives HI/LO toward the writeback mux for MFHI/MFLO.

Parameters:
WIDTH, 32, operand width and width of each of HI and LO
CNT_W, 6, iteration counter width; must hold the value WIDTH

Ports:
clk  input  1  clock, all state updates on rising edge
rst  input  1  reset, asynchronous, active-high
start  input  1  begin operation; sampled only in IDLE
op  input  2  operation: 00 MULTU, 01 MULT, 10 DIVU, 11 DIV
rs_data  input  WIDTH  multiplicand or dividend (register file read_data1)
rt_data  input  WIDTH  multiplier or divisor (register file read_data2)
hi_we  input  1  MTHI write enable
lo_we  input  1  MTLO write enable
wdata  input  WIDTH  MTHI/MTLO data (rs)
busy  output  1  operation in progress; stalls the core
done  output  1  one-cycle pulse; HI/LO hold the new result
hi  output  WIDTH  HI register
lo  output  WIDTH  LO register

Behaviour:
- Reset (asynchronous, any state, including mid-operation): state IDLE, hi=0, lo=0, done=0, busy=0, counter=0. Any partial result is discarded.
- States:
  - IDLE: busy=0. start=1 at an edge latches op, the operand magnitudes, and the result-sign flags. Counter clears and state goes to RUN.
  - RUN: busy=1. One iteration per edge. After the 32nd RUN edge, state goes to FIX.
  - FIX: busy=1. Applies sign fixup. At this edge it writes hi/lo, sets done=1, and returns to IDLE.
- Latency: start sampled at edge E0. busy is high from after E0 until after E33 (33 cycles). hi/lo update and done rises at E33. done clears at E34 unless a new operation completes.
- Start while busy is ignored; no queueing.
- Multiply: shift-add on magnitudes, producing a 64-bit product with {hi,lo}=product.
  - MULT: operands are two's complement; product is negated if the operand signs differ.
  - MULTU: operands are unsigned.
- Divide: restoring division on magnitudes; lo=quotient, hi=remainder.
  - DIV: quotient truncates toward zero. Remainder takes the sign of the dividend.
  - DIV 0x80000000 / 0xFFFFFFFF: lo=0x80000000, hi=0. No trap.
- Divide by zero (rt_data=0, DIV or DIVU): full latency is still used. Result is lo=0xFFFFFFFF, hi=rs_data as latched.
- MTHI/MTLO:
  - In IDLE, hi_we/lo_we write wdata at the edge and are visible next cycle. Both may be asserted together.
  - While busy, the writes are ignored.
  - If start and hi_we/lo_we are both asserted in IDLE, start wins and the writes are dropped.
- hi/lo hold their old values throughout RUN and change only at FIX, MTHI/MTLO, or reset.
- Operands are latched at start; changes to rs_data/rt_data during RUN have no effect.

Test Plan:
- MULTU rs=0xFFFFFFFF, rt=0xFFFFFFFF -> busy for 33 cycles; at done, hi=0xFFFFFFFE, lo=0x00000001.
- MULT rs=0xFFFFFFFD (-3), rt=5 -> hi=0xFFFFFFFF, lo=0xFFFFFFF1. DIV rs=0xFFFFFFF9 (-7), rt=2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF.
- DIVU rs=100, rt=0 -> lo=0xFFFFFFFF, hi=0x00000064. DIV rs=0x80000000, rt=0xFFFFFFFF -> lo=0x80000000, hi=0.
- Start DIVU 10/3 and pulse start plus hi_we (wdata=0x1234) at cycle 5 -> both ignored; result lo=3, hi=1; exactly one done pulse.
- Assert rst at cycle 12 of a MULT -> hi=lo=0, busy=0 immediately; no done pulse. A new MULTU 6*7 then gives lo=42, hi=0.
- In IDLE, hi_we=1 and lo_we=1 with wdata=0xA5A5A5A5 -> hi=lo=0xA5A5A5A5 next cycle. Assert start and lo_we together -> lo is unchanged until the operation's result is written.
